// File: rtl/ual_seq.sv
// Multi-cycle ALU with start/busy/done handshake and signed Booth radix-2 multiplier.
// Define UAL_SEQ_DIV_EN to include the unsigned restoring divider on opcode 9.
module ual_seq #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [3:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] c,
   output logic           err
);

   localparam int CW = $clog2(W + 1);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;

   typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

   state_t         state, state_nx;
   logic [3:0]     op_r;
   logic [W-1:0]   a_r, b_r;
   logic [CW-1:0]  cnt;
   logic [W:0]     acc;
   logic [W-1:0]   q;
   logic           q_m1;
   logic           iter_op;
   logic [W:0]     a_ext, booth_sum;
   logic [W-1:0]   sub_d;
   logic [2*W-1:0] alu_c;
   logic           alu_err;
`ifdef UAL_SEQ_DIV_EN
   logic [W-1:0]   rem, rem_nx, div_diff;
   logic [W:0]     div_sh;
   logic           div_ge;
`endif

`ifdef UAL_SEQ_DIV_EN
   assign iter_op = (op == OP_MUL) || (op == OP_DIV);
`else
   assign iter_op = (op == OP_MUL);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ITER spends W edges iterating plus one edge writing the result back
   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      case (state)
         IDLE: if (start) state_nx = iter_op ? ITER : EXEC;
         EXEC: state_nx = FIN;
         ITER: if (cnt == CW'(W)) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      a_ext = {a_r[W-1], a_r};
      case ({q[0], q_m1})
         2'b01:   booth_sum = acc + a_ext;
         2'b10:   booth_sum = acc - a_ext;
         default: booth_sum = acc;
      endcase
   end

`ifdef UAL_SEQ_DIV_EN
   always_comb begin
      div_sh   = {rem, q[W-1]};
      div_ge   = (div_sh >= {1'b0, b_r});
      div_diff = div_sh[W-1:0] - b_r;
      rem_nx   = div_ge ? div_diff : div_sh[W-1:0];
   end
`endif

   always_comb begin
      alu_c   = '0;
      alu_err = 1'b0;
      sub_d   = a_r - b_r;
      case (op_r)
         OP_ADD: alu_c = {{(W-1){1'b0}}, {1'b0, a_r} + {1'b0, b_r}};
         OP_SUB: alu_c = {{W{sub_d[W-1]}}, sub_d};
         OP_AND: alu_c = {{W{1'b0}}, a_r & b_r};
         OP_OR:  alu_c = {{W{1'b0}}, a_r | b_r};
         OP_XOR: alu_c = {{W{1'b0}}, a_r ^ b_r};
         OP_NOT: alu_c = {{W{1'b0}}, ~a_r};
         OP_SHL: alu_c = {{W{1'b0}}, a_r} << b_r;
         OP_SHR: alu_c = {{W{1'b0}}, a_r >> b_r};
         default: begin
            alu_c   = '0;
            alu_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done <= 1'b0;
         c    <= '0;
         err  <= 1'b0;
         op_r <= '0;
         a_r  <= '0;
         b_r  <= '0;
         cnt  <= '0;
         acc  <= '0;
         q    <= '0;
         q_m1 <= 1'b0;
`ifdef UAL_SEQ_DIV_EN
         rem  <= '0;
`endif
      end else begin
         done <= (state == FIN);
         case (state)
            IDLE: if (start) begin
               op_r <= op;
               a_r  <= a;
               b_r  <= b;
               cnt  <= '0;
               acc  <= '0;
               q_m1 <= 1'b0;
`ifdef UAL_SEQ_DIV_EN
               rem  <= '0;
               q    <= (op == OP_DIV) ? a : b;
`else
               q    <= b;
`endif
            end
            EXEC: begin
               c   <= alu_c;
               err <= alu_err;
            end
            ITER: begin
               if (cnt == CW'(W)) begin
`ifdef UAL_SEQ_DIV_EN
                  if (op_r == OP_DIV) begin
                     c   <= {rem, q};
                     err <= (b_r == '0);
                  end else begin
                     c   <= {acc[W-1:0], q};
                     err <= 1'b0;
                  end
`else
                  c   <= {acc[W-1:0], q};
                  err <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + CW'(1);
`ifdef UAL_SEQ_DIV_EN
                  if (op_r == OP_DIV) begin
                     rem <= rem_nx;
                     q   <= {q[W-2:0], div_ge};
                  end else begin
                     acc  <= {booth_sum[W], booth_sum[W:1]};
                     q    <= {booth_sum[0], q[W-1:1]};
                     q_m1 <= q[0];
                  end
`else
                  acc  <= {booth_sum[W], booth_sum[W:1]};
                  q    <= {booth_sum[0], q[W-1:1]};
                  q_m1 <= q[0];
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ual_seq.sv
// Scoreboard bench for ual_seq: directed vectors, random ops, handshake noise and mid-op reset.
module tb_ual_seq;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst, start;
   logic [3:0]     op;
   logic [W-1:0]   a, b;
   logic           busy, done, err;
   logic [2*W-1:0] c;

   typedef struct {
      logic [2*W-1:0] c;
      logic           err;
      int             lat;
      int             t0;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   ual_seq #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .c(c), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic longint sgn(input longint x);
      return (x >= (64'sd1 <<< (W-1))) ? x - (64'sd1 <<< W) : x;
   endfunction

   function automatic exp_t model(input int o, input longint x, input longint y);
      exp_t   e;
      longint r, m1, m2;
      m1    = (64'sd1 <<< W) - 1;
      m2    = (64'sd1 <<< (2*W)) - 1;
      e.err = 1'b0;
      e.lat = 2;
      e.t0  = 0;
      r     = 0;
      case (o)
         0: r = x + y;
         1: r = sgn((x - y) & m1);
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = (~x) & m1;
         6: r = (y >= 2*W) ? 0 : (x <<< y);
         7: r = (y >= W) ? 0 : (x >>> y);
         8: begin
            r     = sgn(x) * sgn(y);
            e.lat = W + 2;
         end
`ifdef UAL_SEQ_DIV_EN
         9: begin
            e.lat = W + 2;
            if (y == 0) begin
               r     = (x <<< W) | m1;
               e.err = 1'b1;
            end else begin
               r = ((x % y) <<< W) | (x / y);
            end
         end
`endif
         default: begin
            r     = 0;
            e.err = 1'b1;
         end
      endcase
      r   = r & m2;
      e.c = r[2*W-1:0];
      return e;
   endfunction

   task automatic noise();
      start = 1'($urandom_range(0, 1));
      op    = 4'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input int o, input int x, input int y);
      exp_t e;
      int   n;
      n = 0;
      while (busy && n < 100) begin
         noise();
         @(negedge clk);
         n++;
      end
      if (busy) chk("wait_idle_timeout", 1, 0);
      start = 1'b1;
      op    = 4'(o);
      a     = W'(x);
      b     = W'(y);
      @(posedge clk);
      #1;
      e    = model(o, longint'(x), longint'(y));
      e.t0 = cyc;
      sb.push_back(e);
      noise();
      @(negedge clk);
      chk("busy_after_accept", longint'(busy), 1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("c", longint'(c), longint'(e.c));
            chk("err", longint'(err), longint'(e.err));
            chk("latency", longint'(cyc - e.t0), longint'(e.lat));
            chk("busy_at_done", longint'(busy), 0);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_c", longint'(c), 0);
      chk("rst_err", longint'(err), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) issue(i, 4, 2);
      issue(8, 4'hD, 5);
      issue(8, 4'h8, 4'h8);
      issue(8, 7, 4'h8);
      issue(9, 13, 4);
      issue(9, 9, 0);
      issue(15, 3, 3);
      issue(11, 1, 2);
      issue(7, 4'hF, 4'hF);
      issue(6, 1, 7);
      issue(6, 1, 8);

      for (int i = 0; i < 150; i++) begin
         if (($urandom & 3) == 0) issue(8 + int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         else issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end

      n = 0;
      while (busy && n < 100) begin
         start = 1'b0;
         @(negedge clk);
         n++;
      end
      issue(8, 4'hD, 5);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_c", longint'(c), 0);
      chk("abort_err", longint'(err), 0);
      chk("abort_done", longint'(done), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);

      issue(1, 2, 5);
      start = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", longint'(sb.size()), 0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
